dshot_rx_channel: RTL and testbench

- Single-channel DShot600 frame receiver. Sits directly upstream of blctrlHandler.
- Decodes one flight-controller DShot line into an 8-bit BL-Ctrl target speed plus a motor enable.
- Eight instances are packed into targetSpeedFlat[63:0] and motorEnable[7:0].
- Provides CRC checking, command detection and a failsafe timeout.

---
 rtl/dshot_pkg.sv | 21 ++
 rtl/dshot_rx_channel_if.sv | 30 +++
 rtl/dshot_rx_array.sv | 55 +++++
 rtl/dshot_rx_channel.sv | 184 ++++++++++++++++++
 tb/tb_dshot_rx_channel.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dshot_pkg.sv
// Shared definitions for the DShot600 receive path.
// Holds the frame constants, the receiver state encoding and the DShot
// 4-bit checksum function used by dshot_rx_channel.
package dshot_pkg;

    localparam int unsigned DSHOT_FRAME_BITS   = 16;
    localparam int unsigned DSHOT_CMD_MAX      = 47;
    localparam int unsigned DSHOT_THROTTLE_MIN = 48;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } dshot_state_t;

    // XOR of the three nibbles of the 12-bit payload (throttle + telemetry).
    function automatic logic [3:0] dshot_crc(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

endpackage

// File: rtl/dshot_rx_channel_if.sv
// Decoded-output bundle of one DShot receive channel.
//   target_speed  : BL-Ctrl speed 0..249
//   motor_enable  : motor armed
//   frame_valid   : 1-cycle pulse per good throttle frame
//   crc_error     : 1-cycle pulse per frame with bad checksum
//   cmd_valid     : 1-cycle pulse per good command frame (1..47)
//   cmd           : last command value
//   telemetry_req : telemetry bit of the last good frame
// master: the receiver driving the bundle; slave: the consumer.
interface dshot_rx_channel_if;

    logic [7:0] target_speed;
    logic       motor_enable;
    logic       frame_valid;
    logic       crc_error;
    logic       cmd_valid;
    logic [5:0] cmd;
    logic       telemetry_req;

    modport master (
        output target_speed, motor_enable, frame_valid, crc_error,
               cmd_valid, cmd, telemetry_req
    );

    modport slave (
        input  target_speed, motor_enable, frame_valid, crc_error,
               cmd_valid, cmd, telemetry_req
    );

endinterface

// File: rtl/dshot_rx_array.sv
// Eight DShot receive channels feeding blctrlHandler.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   dshot_in[7:0]   : raw DShot lines, one per motor
//   targetSpeedFlat : channel n speed in [8n+7:8n] (channel 7 in [63:56])
//   motorEnable     : per-channel motor enable
//   frame_valid, crc_error, cmd_valid, telemetry_req : per-channel flags
//   cmd_flat        : channel n command in [6n+5:6n]
module dshot_rx_array
    import dshot_pkg::*;
#(
    parameter int unsigned BIT_THRESH  = 15,
    parameter int unsigned MIN_HIGH    = 4,
    parameter int unsigned MAX_HIGH    = 24,
    parameter int unsigned FRAME_GAP   = 40,
    parameter int unsigned TIMEOUT_CYC = 800000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  dshot_in,
    output logic [63:0] targetSpeedFlat,
    output logic [7:0]  motorEnable,
    output logic [7:0]  frame_valid,
    output logic [7:0]  crc_error,
    output logic [7:0]  cmd_valid,
    output logic [7:0]  telemetry_req,
    output logic [47:0] cmd_flat
);

    for (genvar g = 0; g < 8; g++) begin : g_ch
        dshot_rx_channel_if bus ();

        dshot_rx_channel #(
            .BIT_THRESH  (BIT_THRESH),
            .MIN_HIGH    (MIN_HIGH),
            .MAX_HIGH    (MAX_HIGH),
            .FRAME_GAP   (FRAME_GAP),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .dshot_in (dshot_in[g]),
            .rx       (bus.master)
        );

        assign targetSpeedFlat[8*g +: 8] = bus.target_speed;
        assign motorEnable[g]            = bus.motor_enable;
        assign frame_valid[g]            = bus.frame_valid;
        assign crc_error[g]              = bus.crc_error;
        assign cmd_valid[g]              = bus.cmd_valid;
        assign telemetry_req[g]          = bus.telemetry_req;
        assign cmd_flat[6*g +: 6]        = bus.cmd;
    end

endmodule

// File: rtl/dshot_rx_channel.sv
// Single-channel DShot600 frame receiver.
// Ports:
//   clk      : system clock (16 MHz default timing)
//   rst_n    : asynchronous active-low reset
//   dshot_in : raw DShot line, asynchronous to clk
//   rx       : decoded outputs (dshot_rx_channel_if.master)
// The line is synchronised (2 flops) and edge-detected; pulse widths are
// measured on the synchronised signal, 16 bits are shifted in MSB first,
// then checksum, command/throttle decode and a failsafe timeout are applied.
module dshot_rx_channel
    import dshot_pkg::*;
#(
    parameter int unsigned BIT_THRESH  = 15,
    parameter int unsigned MIN_HIGH    = 4,
    parameter int unsigned MAX_HIGH    = 24,
    parameter int unsigned FRAME_GAP   = 40,
    parameter int unsigned TIMEOUT_CYC = 800000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dshot_in,
    dshot_rx_channel_if.master  rx
);

    localparam int unsigned HW = $clog2(MAX_HIGH + 2);
    localparam int unsigned LW = $clog2(FRAME_GAP + 2);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [HW-1:0] BIT_THRESH_C = HW'(BIT_THRESH);
    localparam logic [HW-1:0] MIN_HIGH_C   = HW'(MIN_HIGH);
    localparam logic [HW-1:0] MAX_HIGH_C   = HW'(MAX_HIGH);
    localparam logic [LW-1:0] FRAME_GAP_C  = LW'(FRAME_GAP);
    localparam logic [TW-1:0] TIMEOUT_C    = TW'(TIMEOUT_CYC);

    logic [1:0]    sync_q;
    logic          line, line_q, rise;

    dshot_state_t  state, state_n;
    logic [HW-1:0] high_cnt, high_cnt_n;
    logic [LW-1:0] low_cnt, low_cnt_n, low_inc;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [15:0]   shreg, shreg_n;
    logic          bit_val, frame_done;
    logic [15:0]   frame_word;

    logic [11:0]   v;
    logic [10:0]   thr;
    logic          crc_ok, good, is_cmd, is_disarm;
    logic [7:0]    speed_calc;
    logic [TW-1:0] tmo;

    assign line = sync_q[1];
    assign rise = line & ~line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            line_q   <= 1'b0;
            state    <= ST_IDLE;
            high_cnt <= '0;
            low_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            sync_q   <= {sync_q[0], dshot_in};
            line_q   <= line;
            state    <= state_n;
            high_cnt <= high_cnt_n;
            low_cnt  <= low_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
        end
    end

    always_comb begin
        state_n    = state;
        high_cnt_n = high_cnt;
        low_cnt_n  = low_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        frame_done = 1'b0;
        bit_val    = (high_cnt >= BIT_THRESH_C);
        frame_word = {shreg[14:0], bit_val};
        // low counter saturates just above the gap threshold
        low_inc    = (low_cnt > FRAME_GAP_C) ? low_cnt : low_cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                if (line) begin
                    low_cnt_n = '0;
                    if (rise && (low_cnt > FRAME_GAP_C)) begin
                        state_n    = ST_HIGH;
                        high_cnt_n = HW'(1);
                        bit_cnt_n  = '0;
                    end
                end else begin
                    low_cnt_n = low_inc;
                end
            end
            ST_HIGH: begin
                if (line) begin
                    if (high_cnt >= MAX_HIGH_C) begin
                        state_n   = ST_IDLE;
                        low_cnt_n = '0;
                    end else begin
                        high_cnt_n = high_cnt + 1'b1;
                    end
                end else if (high_cnt < MIN_HIGH_C) begin
                    state_n   = ST_IDLE;
                    low_cnt_n = LW'(1);
                end else begin
                    shreg_n   = frame_word;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 4'(DSHOT_FRAME_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_n    = ST_IDLE;
                        low_cnt_n  = '0;
                    end else begin
                        state_n   = ST_LOW;
                        low_cnt_n = LW'(1);
                    end
                end
            end
            ST_LOW: begin
                if (line) begin
                    state_n    = ST_HIGH;
                    high_cnt_n = HW'(1);
                end else begin
                    // carry the count so the next rise can open a frame
                    low_cnt_n = low_inc;
                    if (low_inc > FRAME_GAP_C) state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // frame decode, evaluated on the cycle the 16th bit is shifted in
    assign v          = frame_word[15:4];
    assign thr        = v[11:1];
    assign crc_ok     = (frame_word[3:0] == dshot_crc(v));
    assign good       = frame_done & crc_ok;
    assign is_disarm  = (thr == '0);
    assign is_cmd     = !is_disarm && (thr <= 11'(DSHOT_CMD_MAX));
    assign speed_calc = 8'((thr - 11'(DSHOT_THROTTLE_MIN)) >> 3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx.target_speed  <= '0;
            rx.motor_enable  <= 1'b0;
            rx.frame_valid   <= 1'b0;
            rx.crc_error     <= 1'b0;
            rx.cmd_valid     <= 1'b0;
            rx.cmd           <= '0;
            rx.telemetry_req <= 1'b0;
            tmo              <= TIMEOUT_C;
        end else begin
            rx.frame_valid <= good & ~is_cmd;
            rx.crc_error   <= frame_done & ~crc_ok;
            rx.cmd_valid   <= good & is_cmd;
            if (good) begin
                // a good frame takes priority over a coincident expiry
                rx.telemetry_req <= v[0];
                tmo              <= TIMEOUT_C;
                if (is_cmd) begin
                    rx.cmd <= thr[5:0];
                end else if (is_disarm) begin
                    rx.motor_enable <= 1'b0;
                    rx.target_speed <= '0;
                end else begin
                    rx.motor_enable <= 1'b1;
                    rx.target_speed <= speed_calc;
                end
            end else if (tmo != '0) begin
                tmo <= tmo - 1'b1;
                if (tmo == TW'(1)) begin
                    rx.motor_enable <= 1'b0;
                    rx.target_speed <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dshot_rx_channel.sv
// Self-checking bench for dshot_rx_channel: directed frames from the test
// plan plus randomized frames, compared every cycle against a frame-level
// model of the decoded outputs.
module tb_dshot_rx_channel;

    localparam int T = 3000;   // shortened failsafe timeout

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic dshot_in = 1'b0;

    dshot_rx_channel_if bus ();

    dshot_rx_channel #(
        .BIT_THRESH  (15),
        .MIN_HIGH    (4),
        .MAX_HIGH    (24),
        .FRAME_GAP   (40),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dshot_in (dshot_in),
        .rx       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int frame;
    } ev_t;

    ev_t evq[$];
    ev_t e;
    int  m_speed, m_en, m_cmd, m_tlm, m_fv, m_ce, m_cv;
    int  ref_cyc;
    bit  model_on = 1'b0;
    bit  vn;
    int  last_fall = 0;
    int  last_ev   = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level meaning of one decoded 16-bit word.
    function automatic bit model_apply(input int f);
        int v, thr;
        v   = (f >> 4) & 12'hFFF;
        thr = v >> 1;
        if ((f & 15) != ((v ^ (v >> 4) ^ (v >> 8)) & 15)) begin
            m_ce = 1;
            return 1'b0;
        end
        m_tlm   = v & 1;
        ref_cyc = cyc;
        if (thr == 0) begin
            m_en = 0; m_speed = 0; m_fv = 1;
        end else if (thr <= 47) begin
            m_cmd = thr; m_cv = 1;
        end else begin
            m_speed = (thr - 48) / 8; m_en = 1; m_fv = 1;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        evq.delete();
        m_speed = 0; m_en = 0; m_cmd = 0; m_tlm = 0;
        m_fv = 0; m_ce = 0; m_cv = 0;
        ref_cyc   = cyc;
        last_fall = cyc;
        model_on  = 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rst_n && model_on) begin
            vn = 1'b0;
            m_fv = 0; m_ce = 0; m_cv = 0;
            while (evq.size() != 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                if (e.cyc == cyc && model_apply(e.frame)) vn = 1'b1;
            end
            if (!vn && cyc == ref_cyc + T) begin
                m_speed = 0; m_en = 0;
            end
            checks++;
            if (int'(bus.target_speed) != m_speed || int'(bus.motor_enable) != m_en ||
                int'(bus.frame_valid) != m_fv || int'(bus.crc_error) != m_ce ||
                int'(bus.cmd_valid) != m_cv || int'(bus.cmd) != m_cmd ||
                int'(bus.telemetry_req) != m_tlm) begin
                errors++;
                $display("FAIL outputs cycle %0d: got spd=%0d en=%0d fv=%0d ce=%0d cv=%0d cmd=%0d tlm=%0d, expected spd=%0d en=%0d fv=%0d ce=%0d cv=%0d cmd=%0d tlm=%0d",
                         cyc, bus.target_speed, bus.motor_enable, bus.frame_valid,
                         bus.crc_error, bus.cmd_valid, bus.cmd, bus.telemetry_req,
                         m_speed, m_en, m_fv, m_ce, m_cv, m_cmd, m_tlm);
            end
        end
    end

    task automatic hold(input logic lvl, input int n);
        if (lvl == 1'b0 && dshot_in == 1'b1) last_fall = cyc;
        dshot_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // abort_kind: 0 none, 1 two-cycle glitch after bit abort_bit, 2 30-cycle high
    task automatic send_frame(input int f, input int gap, input bit rnd,
                              input int abort_kind, input int abort_bit);
        int  L, hi, lo;
        bit  b, accept;
        hold(1'b0, gap);
        L = cyc - last_fall;
        accept = (L >= 42) && (abort_kind == 0);
        for (int i = 15; i >= 0; i--) begin
            b = ((f >> i) & 1) != 0;
            if (rnd) begin
                hi = b ? $urandom_range(24, 15) : $urandom_range(14, 4);
                lo = $urandom_range(30, 2);
            end else begin
                hi = b ? 20 : 10;
                lo = b ? 7 : 17;
            end
            if (abort_kind == 2 && i == abort_bit) hi = 30;
            hold(1'b1, hi);
            if (i == 0) begin
                dshot_in  = 1'b0;
                last_fall = cyc;
            end else begin
                hold(1'b0, lo);
                if (abort_kind == 1 && i == abort_bit) begin
                    hold(1'b1, 2);
                    hold(1'b0, 5);
                end
            end
        end
        if (accept) begin
            evq.push_back('{cyc: cyc + 3, frame: f});
            last_ev = cyc + 3;
        end else begin
            last_ev = -1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ev, cat, thr, tlm, v, crc, gap, ak, ab;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset target_speed", int'(bus.target_speed), 0);
        chk("reset motor_enable", int'(bus.motor_enable), 0);
        chk("reset frame_valid", int'(bus.frame_valid), 0);
        chk("reset crc_error", int'(bus.crc_error), 0);
        chk("reset cmd_valid", int'(bus.cmd_valid), 0);
        chk("reset cmd", int'(bus.cmd), 0);
        chk("reset telemetry_req", int'(bus.telemetry_req), 0);
        rst_n = 1'b1;
        model_reset();

        send_frame(16'h830B, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        chk("830B frame_valid", int'(bus.frame_valid), 1);
        chk("830B target_speed", int'(bus.target_speed), 125);
        chk("830B motor_enable", int'(bus.motor_enable), 1);
        chk("830B telemetry_req", int'(bus.telemetry_req), 0);
        align();

        send_frame(16'h0606, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        chk("0606 target_speed", int'(bus.target_speed), 0);
        chk("0606 motor_enable", int'(bus.motor_enable), 1);
        align();
        send_frame(16'hFFEE, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        chk("FFEE target_speed", int'(bus.target_speed), 249);
        chk("FFEE motor_enable", int'(bus.motor_enable), 1);
        align();

        send_frame(16'h830B, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        align();
        send_frame(16'h830A, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        chk("830A crc_error", int'(bus.crc_error), 1);
        chk("830A frame_valid", int'(bus.frame_valid), 0);
        chk("830A target_speed", int'(bus.target_speed), 125);
        align();

        send_frame(16'h0000, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        chk("0000 frame_valid", int'(bus.frame_valid), 1);
        chk("0000 motor_enable", int'(bus.motor_enable), 0);
        chk("0000 target_speed", int'(bus.target_speed), 0);
        align();
        send_frame(16'h00BB, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        chk("00BB cmd_valid", int'(bus.cmd_valid), 1);
        chk("00BB cmd", int'(bus.cmd), 5);
        chk("00BB telemetry_req", int'(bus.telemetry_req), 1);
        chk("00BB motor_enable", int'(bus.motor_enable), 0);
        align();

        send_frame(16'h830B, 60, 1'b0, 1, 8);
        send_frame(16'h830B, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        chk("after glitch target_speed", int'(bus.target_speed), 125);
        align();
        send_frame(16'h830B, 60, 1'b0, 2, 5);
        send_frame(16'hFFEE, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        chk("after long high target_speed", int'(bus.target_speed), 249);
        align();

        send_frame(16'h0606, 20, 1'b0, 0, 0);
        hold(1'b0, 10);
        chk("short gap dropped target_speed", int'(bus.target_speed), 249);

        send_frame(16'h830B, 60, 1'b0, 0, 0);
        ev = last_ev;
        wait_cyc(ev + T - 1);
        chk("pre-expiry motor_enable", int'(bus.motor_enable), 1);
        chk("pre-expiry target_speed", int'(bus.target_speed), 125);
        wait_cyc(ev + T);
        chk("expiry motor_enable", int'(bus.motor_enable), 0);
        chk("expiry target_speed", int'(bus.target_speed), 0);
        align();

        send_frame(16'hFFEE, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        align();
        hold(1'b0, 60);
        hold(1'b1, 20);
        hold(1'b0, 7);
        hold(1'b1, 10);
        rst_n    = 1'b0;
        model_on = 1'b0;
        #1;
        chk("async reset target_speed", int'(bus.target_speed), 0);
        chk("async reset motor_enable", int'(bus.motor_enable), 0);
        chk("async reset telemetry_req", int'(bus.telemetry_req), 0);
        dshot_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        send_frame(16'h830B, 60, 1'b0, 0, 0);
        wait_cyc(last_ev);
        chk("post reset 830B target_speed", int'(bus.target_speed), 125);
        align();

        for (int n = 0; n < 40; n++) begin
            cat = $urandom_range(9, 0);
            if (cat == 0)      thr = 0;
            else if (cat < 3)  thr = $urandom_range(47, 1);
            else               thr = $urandom_range(2047, 48);
            tlm = $urandom_range(1, 0);
            v   = thr * 2 + tlm;
            crc = (v ^ (v >> 4) ^ (v >> 8)) & 15;
            if ($urandom_range(6, 0) == 0) crc = crc ^ $urandom_range(15, 1);
            gap = ($urandom_range(9, 0) == 0) ? $urandom_range(30, 5)
                                              : $urandom_range(90, 45);
            ab  = $urandom_range(9, 0);
            if (ab == 0) begin
                ak = 1; ab = $urandom_range(15, 1);
            end else if (ab == 1) begin
                ak = 2; ab = $urandom_range(15, 0);
            end else begin
                ak = 0; ab = 0;
            end
            send_frame((v << 4) | crc, gap, 1'b1, ak, ab);
        end
        hold(1'b0, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
